hms_alarm_clock_core: RTL and testbench

- Single-clock-domain hour:minute:second time-keeping core with setup and alarm modes.
- Replaces derived-clock counting with clock-enable ticks from the system clock.
- Adds an hour field, a 12/24-hour display format, an alarm register with compare and ring timeout, and parametrised rates.
- Sits between the push-button inputs and the BCD-split / 7-segment display path of the top-level clock.

---
 rtl/hms_alarm_clock_core.sv | 234 +++++++++++++++++++++++
 tb/tb_hms_alarm_clock_core.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hms_alarm_clock_core.sv
// hms_alarm_clock_core: hour:minute:second time keeper with setup mode,
// alarm register, ring timeout and 12/24-hour display conversion.
// Everything runs on clk; the time base and button sampling are clock
// enables derived from counters, not divided clocks.
// Button inputs are expected to be synchronous to clk (synchronised at the
// board top level).
module hms_alarm_clock_core #(
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_HZ  = 1,
  parameter int DEB_HZ   = 100,
  parameter int RING_SEC = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  input  logic       i_sw3,
  input  logic       i_fmt12,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_pm,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_alarm_en,
  output logic       o_alarm,
  output logic       o_tick
);

  localparam int TDIV = CLK_HZ / TICK_HZ;
  localparam int DDIV = CLK_HZ / DEB_HZ;
  localparam int TW   = (TDIV > 1) ? $clog2(TDIV) : 1;
  localparam int DW   = (DDIV > 1) ? $clog2(DDIV) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TDIV - 1);
  localparam logic [DW-1:0] DMAX = DW'(DDIV - 1);
  localparam logic [5:0]    RMAX = 6'(RING_SEC - 1);

  typedef enum logic [1:0] {M_CLOCK = 2'd0, M_SETUP = 2'd1, M_ALARM = 2'd2} mode_t;
  typedef enum logic [1:0] {P_SEC = 2'd0, P_MIN = 2'd1, P_HOUR = 2'd2} pos_t;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [DW-1:0] deb_cnt;
  logic          deb_stb;
  logic          smp_fresh;
  logic [3:0]    sw_n, smp_new, smp_old, press;
  logic          p_mode, p_pos, p_inc, p_en, consume, inc_en;
  mode_t         mode_q, mode_d;
  pos_t          pos_q, pos_d;
  logic [5:0]    sec_q, min_q, am_q;
  logic [4:0]    hour_q, ah_q;
  logic          sec_wrap, min_wrap, hour_wrap;
  logic [5:0]    nxt_min;
  logic [4:0]    nxt_hour;
  logic          hit, hit_q;
  logic          alarm_q, alarm_en_q;
  logic [5:0]    ring_cnt;
  logic [5:0]    disp_sec, disp_min;
  logic [4:0]    disp_hour, hour12;

  // time-base counter; the tick is the cycle spent at the terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               tick_cnt <= '0;
    else if (tick_cnt == TMAX) tick_cnt <= '0;
    else                       tick_cnt <= tick_cnt + 1'b1;
  end
  assign tick   = (tick_cnt == TMAX);
  assign o_tick = tick;

  // button sample strobe counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               deb_cnt <= '0;
    else if (deb_cnt == DMAX) deb_cnt <= '0;
    else                      deb_cnt <= deb_cnt + 1'b1;
  end
  assign deb_stb = (deb_cnt == DMAX);

  // two-sample history per button; history starts as "released"
  assign sw_n = {i_sw3, i_sw2, i_sw1, i_sw0};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_new   <= '1;
      smp_old   <= '1;
      smp_fresh <= 1'b0;
    end else begin
      smp_fresh <= deb_stb;
      if (deb_stb) begin
        smp_old <= smp_new;
        smp_new <= sw_n;
      end
    end
  end
  // press = released-then-pressed, flagged for the one cycle after a sample
  assign press = {4{smp_fresh}} & smp_old & ~smp_new;

  assign p_mode  = press[0];
  assign p_pos   = press[1];
  assign p_inc   = press[2];
  assign p_en    = press[3];
  // a ringing alarm swallows the next mode/position/increment press
  assign consume = alarm_q & (p_mode | p_pos | p_inc);
  // mode and position presses take priority over the increment
  assign inc_en  = p_inc & ~p_mode & ~p_pos & ~consume;

  // mode / position state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= M_CLOCK;
      pos_q  <= P_SEC;
    end else begin
      mode_q <= mode_d;
      pos_q  <= pos_d;
    end
  end

  // mode / position next state
  always_comb begin
    mode_d = mode_q;
    pos_d  = pos_q;
    if (!consume) begin
      if (p_mode) begin
        case (mode_q)
          M_CLOCK: begin mode_d = M_SETUP; pos_d = P_SEC; end
          M_SETUP: begin mode_d = M_ALARM; pos_d = P_MIN; end
          default: begin mode_d = M_CLOCK; pos_d = P_SEC; end
        endcase
      end else if (p_pos) begin
        if (mode_q == M_ALARM) begin
          pos_d = (pos_q == P_MIN) ? P_HOUR : P_MIN;
        end else begin
          case (pos_q)
            P_SEC:   pos_d = P_MIN;
            P_MIN:   pos_d = P_HOUR;
            default: pos_d = P_SEC;
          endcase
        end
      end
    end
  end

  assign sec_wrap  = (sec_q == 6'd59);
  assign min_wrap  = (min_q == 6'd59);
  assign hour_wrap = (hour_q == 5'd23);
  assign nxt_min   = min_wrap ? 6'd0 : min_q + 6'd1;
  assign nxt_hour  = min_wrap ? (hour_wrap ? 5'd0 : hour_q + 5'd1) : hour_q;

  // time counters: run on ticks outside SETUP, field edit inside SETUP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
    end else if (mode_q == M_SETUP) begin
      if (inc_en) begin
        case (pos_q)
          P_SEC:   sec_q  <= sec_wrap  ? 6'd0 : sec_q + 6'd1;
          P_MIN:   min_q  <= min_wrap  ? 6'd0 : min_q + 6'd1;
          default: hour_q <= hour_wrap ? 5'd0 : hour_q + 5'd1;
        endcase
      end
    end else if (tick) begin
      sec_q <= sec_wrap ? 6'd0 : sec_q + 6'd1;
      if (sec_wrap) begin
        min_q  <= nxt_min;
        hour_q <= nxt_hour;
      end
    end
  end

  // alarm register edit in ALARM_SET
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      am_q <= '0;
      ah_q <= '0;
    end else if (mode_q == M_ALARM && inc_en) begin
      if (pos_q == P_MIN)       am_q <= (am_q == 6'd59) ? 6'd0 : am_q + 6'd1;
      else if (pos_q == P_HOUR) ah_q <= (ah_q == 5'd23) ? 5'd0 : ah_q + 5'd1;
    end
  end

  // match only on the carry into :00 while counting in CLOCK mode
  assign hit = tick & (mode_q == M_CLOCK) & alarm_en_q & sec_wrap &
               (nxt_min == am_q) & (nxt_hour == ah_q);

  // alarm enable, ring flag and ring timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q      <= 1'b0;
      alarm_q    <= 1'b0;
      alarm_en_q <= 1'b0;
      ring_cnt   <= '0;
    end else begin
      hit_q      <= hit;
      alarm_en_q <= alarm_en_q ^ p_en;
      if (p_en && alarm_en_q) begin
        alarm_q <= 1'b0;
      end else if (hit_q) begin
        alarm_q  <= 1'b1;
        ring_cnt <= '0;
      end else if (consume) begin
        alarm_q <= 1'b0;
      end else if (alarm_q && tick) begin
        if (ring_cnt == RMAX) alarm_q  <= 1'b0;
        else                  ring_cnt <= ring_cnt + 6'd1;
      end
    end
  end

  // display source and 12-hour conversion
  always_comb begin
    disp_sec  = sec_q;
    disp_min  = min_q;
    disp_hour = hour_q;
    if (mode_q == M_ALARM) begin
      disp_sec  = 6'd0;
      disp_min  = am_q;
      disp_hour = ah_q;
    end
    hour12 = disp_hour;
    if (disp_hour == 5'd0)       hour12 = 5'd12;
    else if (disp_hour > 5'd12)  hour12 = disp_hour - 5'd12;
  end

  assign o_sec      = disp_sec;
  assign o_min      = disp_min;
  assign o_hour     = i_fmt12 ? hour12 : disp_hour;
  assign o_pm       = i_fmt12 & (disp_hour >= 5'd12);
  assign o_mode     = mode_q;
  assign o_position = pos_q;
  assign o_alarm_en = alarm_en_q;
  assign o_alarm    = alarm_q;

endmodule

// File: tb/tb_hms_alarm_clock_core.sv
// Bench for hms_alarm_clock_core: time-of-day model in seconds, alarm in
// minutes-of-day, compared against the DUT every cycle, plus directed checks.
module tb_hms_alarm_clock_core;
  localparam int CLK_HZ = 1000, TICK_HZ = 1, DEB_HZ = 100, RING = 3;
  localparam int TDIV = CLK_HZ / TICK_HZ;
  localparam int DDIV = CLK_HZ / DEB_HZ;

  logic clk = 1'b0, rst_n = 1'b0, fmt12 = 1'b0;
  logic [3:0] sw = 4'hF;
  logic [5:0] o_sec, o_min;
  logic [4:0] o_hour;
  logic [1:0] o_mode, o_position;
  logic o_pm, o_alarm_en, o_alarm, o_tick;

  int n_chk = 0, n_fail = 0;

  hms_alarm_clock_core #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEB_HZ(DEB_HZ),
                         .RING_SEC(RING)) dut (
    .clk(clk), .rst_n(rst_n), .i_sw0(sw[0]), .i_sw1(sw[1]), .i_sw2(sw[2]),
    .i_sw3(sw[3]), .i_fmt12(fmt12), .o_sec(o_sec), .o_min(o_min),
    .o_hour(o_hour), .o_pm(o_pm), .o_mode(o_mode), .o_position(o_position),
    .o_alarm_en(o_alarm_en), .o_alarm(o_alarm), .o_tick(o_tick));

  always #5 clk = ~clk;

  // model state: time in seconds of day, alarm in minutes of day
  int m_t = 0, m_a = 0, m_mode = 0, m_pos = 0, m_ring = 0, m_cyc = 0;
  bit m_en = 0, m_alarm = 0, m_due = 0;
  bit [3:0] m_samp = 4'hF, m_prs = 4'h0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic bit m_tickv();
    return (m_cyc % TDIV) == TDIV - 1;
  endfunction

  task automatic model_reset();
    m_t = 0; m_a = 0; m_mode = 0; m_pos = 0; m_ring = 0; m_cyc = 0;
    m_en = 0; m_alarm = 0; m_due = 0; m_samp = 4'hF; m_prs = 4'h0;
  endtask

  task automatic model_step();
    bit [3:0] p;
    bit tk, cons, inc, hit;
    int s, mi, h;
    p = m_prs;
    tk = m_tickv();
    cons = m_alarm && (p[0] || p[1] || p[2]);
    hit = 0;
    if (m_mode != 1 && tk) begin
      m_t = (m_t + 1) % 86400;
      hit = (m_mode == 0) && m_en && (m_t % 60 == 0) && (m_t / 60 == m_a);
    end
    inc = p[2] && !p[0] && !p[1] && !cons;
    if (inc && m_mode == 1) begin
      s = m_t % 60; mi = (m_t / 60) % 60; h = m_t / 3600;
      if (m_pos == 0) s = (s + 1) % 60;
      else if (m_pos == 1) mi = (mi + 1) % 60;
      else h = (h + 1) % 24;
      m_t = h * 3600 + mi * 60 + s;
    end
    if (inc && m_mode == 2) begin
      if (m_pos == 1) m_a = (m_a / 60) * 60 + (m_a % 60 + 1) % 60;
      else if (m_pos == 2) m_a = ((m_a / 60 + 1) % 24) * 60 + m_a % 60;
    end
    if (p[3] && m_en) m_alarm = 0;
    else if (m_due) begin m_alarm = 1; m_ring = 0; end
    else if (cons) m_alarm = 0;
    else if (m_alarm && tk) begin
      m_ring++;
      if (m_ring >= RING) m_alarm = 0;
    end
    m_due = hit;
    m_en = m_en ^ p[3];
    if (!cons) begin
      if (p[0]) begin
        m_mode = (m_mode + 1) % 3;
        m_pos = (m_mode == 2) ? 1 : 0;
      end else if (p[1]) begin
        if (m_mode == 2) m_pos = (m_pos == 1) ? 2 : 1;
        else m_pos = (m_pos + 1) % 3;
      end
    end
    if (m_cyc % DDIV == DDIV - 1) begin
      m_prs = m_samp & ~sw;
      m_samp = sw;
    end else m_prs = 4'h0;
    m_cyc++;
  endtask

  function automatic int e_h24();
    return (m_mode == 2) ? m_a / 60 : m_t / 3600;
  endfunction
  function automatic int e_hour();
    if (!fmt12) return e_h24();
    return (e_h24() % 12 == 0) ? 12 : e_h24() % 12;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    chk("sec", o_sec, (m_mode == 2) ? 0 : m_t % 60);
    chk("min", o_min, (m_mode == 2) ? m_a % 60 : (m_t / 60) % 60);
    chk("hour", o_hour, e_hour());
    chk("pm", o_pm, (fmt12 && e_h24() >= 12) ? 1 : 0);
    chk("mode", o_mode, m_mode);
    chk("position", o_position, m_pos);
    chk("alarm_en", o_alarm_en, m_en);
    chk("alarm", o_alarm, m_alarm);
    chk("tick", o_tick, m_tickv());
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      sw[k] = 1'b0; cyc(25);
      sw[k] = 1'b1; cyc(25);
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin cyc(1); n++; end while (!m_tickv() && n < 1100);
    if (!m_tickv()) timeout("wait_tick");
  endtask

  task automatic wait_ring();
    int n = 0;
    while (!m_alarm && n < 1500) begin cyc(1); n++; end
    if (!m_alarm) timeout("wait_ring");
  endtask

  // set SETUP-mode seconds to 59, starting at position SEC
  task automatic setup_sec59();
    press(2, (59 - m_t % 60 + 60) % 60);
  endtask

  int ticks[$];

  initial begin
    // reset and idle: ticks at cycles 1000/2000/3000
    cyc(3);
    chk("rst_sec", o_sec, 0);
    chk("rst_hour", o_hour, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 3500; k++) begin
      cyc(1);
      if (o_tick) ticks.push_back(k + 1);
    end
    chk("tick_count", ticks.size(), 3);
    if (ticks.size() == 3) begin
      chk("tick1_cycle", ticks[0], 1000);
      chk("tick2_cycle", ticks[1], 2000);
      chk("tick3_cycle", ticks[2], 3000);
    end
    chk("idle_sec", o_sec, 3);
    chk("idle_min", o_min, 0);
    chk("idle_mode", o_mode, 0);
    chk("idle_alarm_en", o_alarm_en, 0);

    // SETUP: hold, glitch and tick immunity on the seconds field
    press(0, 1);
    chk("setup_mode", o_mode, 1);
    sw[2] = 1'b0; cyc(500); sw[2] = 1'b1; cyc(25);
    chk("hold_once", o_sec, 4);
    while (m_cyc % DDIV != 0) cyc(1);
    sw[2] = 1'b0; cyc(5); sw[2] = 1'b1; cyc(25);
    chk("glitch_ignored", o_sec, 4);
    wait_tick(); wait_tick(); cyc(1);
    chk("setup_tick_hold", o_sec, 4);

    // set 23:59:58 and roll over
    press(2, 54); press(1, 1); press(2, 59); press(1, 1); press(2, 23);
    wait_tick();
    press(0, 2);
    fmt12 = 1'b1; cyc(1);
    chk("pre_sec", o_sec, 58);
    chk("pre_hour12", o_hour, 11);
    chk("pre_pm", o_pm, 1);
    wait_tick(); cyc(1);
    wait_tick(); cyc(1);
    chk("roll_sec", o_sec, 0);
    chk("roll_min", o_min, 0);
    chk("roll_hour12", o_hour, 12);
    chk("roll_pm", o_pm, 0);
    fmt12 = 1'b0; cyc(1);
    chk("roll_hour24", o_hour, 0);

    // alarm 07:30 armed, time 07:29:59
    press(3, 1);
    chk("en_on", o_alarm_en, 1);
    press(0, 2);
    chk("aset_pos", o_position, 1);
    press(2, 30); press(1, 1); press(2, 7);
    chk("aset_min", o_min, 30);
    chk("aset_hour", o_hour, 7);
    press(0, 2);
    setup_sec59();
    press(1, 1); press(2, (29 - (m_t / 60) % 60 + 60) % 60);
    press(1, 1); press(2, (7 - m_t / 3600 + 24) % 24);
    wait_tick();
    press(0, 2);
    chk("t0729_min", o_min, 29);
    chk("t0729_sec", o_sec, 59);
    wait_ring();
    chk("ring_on", o_alarm, 1);
    chk("ring_hour", o_hour, 7);
    chk("ring_min", o_min, 30);
    chk("ring_sec", o_sec, 0);
    wait_tick(); cyc(1);
    wait_tick(); cyc(1);
    chk("ring_2ticks", o_alarm, 1);
    wait_tick(); cyc(1);
    chk("ring_timeout", o_alarm, 0);
    chk("ring_end_sec", o_sec, 3);

    // disarmed: alarm 07:31 must not ring
    press(3, 1);
    chk("en_off", o_alarm_en, 0);
    press(0, 2); press(2, 1);
    chk("aset_min31", o_min, 31);
    press(0, 2);
    setup_sec59();
    wait_tick();
    press(0, 2);
    wait_tick(); cyc(3);
    chk("noring_min", o_min, 31);
    chk("noring_alarm", o_alarm, 0);

    // armed ring at 07:32, cleared by sw1 without side effects
    press(3, 1);
    press(0, 2); press(2, 1);
    press(0, 2);
    setup_sec59();
    wait_tick();
    press(0, 2);
    wait_ring();
    chk("ring2_on", o_alarm, 1);
    chk("ring2_min", o_min, 32);
    press(1, 1);
    chk("sw1_clear", o_alarm, 0);
    chk("sw1_mode", o_mode, 0);
    chk("sw1_pos", o_position, 0);

    // asynchronous reset in ALARM_SET
    press(0, 2);
    fmt12 = 1'b1; cyc(1);
    chk("pre_rst_mode", o_mode, 2);
    rst_n = 1'b0; #1;
    chk("arst_mode", o_mode, 0);
    chk("arst_pos", o_position, 0);
    chk("arst_en", o_alarm_en, 0);
    chk("arst_alarm", o_alarm, 0);
    chk("arst_sec", o_sec, 0);
    chk("arst_min", o_min, 0);
    chk("arst_hour12", o_hour, 12);
    chk("arst_pm", o_pm, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    chk("post_rst_sec", o_sec, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
